// File: rtl/ice_tlx_data_beat_sequencer_pkg.sv
// Shared TLX data-stage types and defaults.
package ice_tlx_data_beat_sequencer_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } seq_state_t;

   // Length entries encode the beat count as N-1 in this many bits.
   localparam int LEN_W       = 6;
   localparam int STALL_W     = 10;
   localparam int HOLDOFF_DEF = 2;
   localparam int TIMEOUT_DEF = 1023;

endpackage

// File: rtl/ice_tlx_data_beat_sequencer_if.sv
// Beat handshake bundle: upstream data path in, downstream write-data out.
interface ice_tlx_data_beat_sequencer_if #(
   parameter int DATA_WIDTH = 512
) ();
   import ice_tlx_data_beat_sequencer_pkg::*;

   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  in_ready;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_last;
   logic [LEN_W-1:0]      out_beat_idx;
   logic                  out_ready;

   // Sequencer side.
   modport master (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_last, out_beat_idx
   );

   // Environment side: upstream source and downstream consumer.
   modport slave (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_last, out_beat_idx
   );
endinterface

// File: rtl/ice_tlx_skid_buf.sv
// Two-entry skid buffer; head entry drives the pop side. Full is derived
// from the registered count so push_ready never depends on pop_ready.
module ice_tlx_skid_buf
   import ice_tlx_data_beat_sequencer_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push_valid,
   input  logic [WIDTH-1:0] push_data,
   output logic             push_ready,
   output logic             pop_valid,
   output logic [WIDTH-1:0] pop_data,
   input  logic             pop_ready,
   output logic [1:0]       count
);
   logic [WIDTH-1:0] ent0;
   logic [WIDTH-1:0] ent1;
   logic             push;
   logic             pop;

   assign push_ready = (count != 2'd2);
   assign pop_valid  = (count != 2'd0);
   assign pop_data   = ent0;
   assign push       = push_valid && push_ready;
   assign pop        = pop_valid && pop_ready;

   // Occupancy and storage; ent0 is always the oldest entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= 2'd0;
         ent0  <= '0;
         ent1  <= '0;
      end else begin
         count <= count + {1'b0, push} - {1'b0, pop};
         if (pop) begin
            if (count == 2'd2)
               ent0 <= ent1;
            else if (push)
               ent0 <= push_data;
         end else if (push) begin
            if (count == 2'd0)
               ent0 <= push_data;
            else
               ent1 <= push_data;
         end
      end
   end
endmodule

// File: rtl/ice_tlx_data_beat_sequencer.sv
// Meters data beats per TLX length entry and pops the length FIFO.
//
// state  | meaning
// IDLE   | waiting for a length entry (after refetch holdoff)
// STREAM | accepting beats of the current command into the skid buffer
module ice_tlx_data_beat_sequencer
   import ice_tlx_data_beat_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH = 512,
   parameter int HOLDOFF    = HOLDOFF_DEF,
   parameter int TIMEOUT    = TIMEOUT_DEF
) (
   input  logic                              clock,
   input  logic                              reset,
   input  logic [LEN_W-1:0]                  fifo_data,
   input  logic                              fifo_data_available,
   input  logic                              fifo_underflow_error,
   input  logic                              fifo_overflow_error,
   output logic                              fifo_rd_done,
   ice_tlx_data_beat_sequencer_if.master     bus,
   output logic                              cmd_done,
   output logic                              busy,
   output logic [1:0]                        err_fifo,
   output logic                              err_timeout
);
   localparam int HOLD_W = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);
   localparam int PW     = DATA_WIDTH + 1 + LEN_W;

   seq_state_t        state;
   seq_state_t        state_nxt;
   logic [LEN_W-1:0]  beats_left;
   logic [LEN_W-1:0]  beat_idx;
   logic [HOLD_W-1:0] holdoff_cnt;
   logic [STALL_W-1:0] stall_cnt;
   logic              start;
   logic              accept;
   logic              in_ready_c;
   logic              skid_ready;
   logic              last_beat;
   logic [1:0]        skid_count;
   logic [PW-1:0]     push_payload;
   logic [PW-1:0]     pop_payload;

   assign last_beat    = (beats_left == '0);
   assign bus.in_ready = in_ready_c;
   assign push_payload = {bus.in_data, last_beat, beat_idx};
   assign {bus.out_data, bus.out_last, bus.out_beat_idx} = pop_payload;
   assign busy         = (state == STREAM) || (skid_count != 2'd0);

   ice_tlx_skid_buf #(.WIDTH(PW)) u_skid (
      .clk        (clock),
      .rst        (reset),
      .push_valid (accept),
      .push_data  (push_payload),
      .push_ready (skid_ready),
      .pop_valid  (bus.out_valid),
      .pop_data   (pop_payload),
      .pop_ready  (bus.out_ready),
      .count      (skid_count)
   );

   // State register.
   always_ff @(posedge clock) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next state, input backpressure and beat accept.
   always_comb begin
      state_nxt  = state;
      start      = 1'b0;
      accept     = 1'b0;
      in_ready_c = 1'b0;
      case (state)
         IDLE: begin
            if (fifo_data_available && (holdoff_cnt == '0)) begin
               state_nxt = STREAM;
               start     = 1'b1;
            end
         end
         STREAM: begin
            in_ready_c = skid_ready;
            accept     = bus.in_valid && skid_ready;
            if (accept && last_beat)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Beat counters, FIFO pop pulse, command-done pulse and refetch holdoff.
   always_ff @(posedge clock) begin
      if (reset) begin
         beats_left   <= '0;
         beat_idx     <= '0;
         fifo_rd_done <= 1'b0;
         cmd_done     <= 1'b0;
         holdoff_cnt  <= '0;
      end else begin
         fifo_rd_done <= start;
         cmd_done     <= accept && last_beat;
         if (start) begin
            beats_left <= fifo_data;
            beat_idx   <= '0;
         end else if (accept) begin
            if (!last_beat)
               beats_left <= beats_left - 1'b1;
            beat_idx <= beat_idx + 1'b1;
         end
         if (fifo_rd_done)
            holdoff_cnt <= HOLD_W'(HOLDOFF);
         else if (holdoff_cnt != '0)
            holdoff_cnt <= holdoff_cnt - 1'b1;
      end
   end

   // Stall watchdog and sticky error flags; the stall only flags, never aborts.
   always_ff @(posedge clock) begin
      if (reset) begin
         stall_cnt   <= '0;
         err_timeout <= 1'b0;
         err_fifo    <= 2'b00;
      end else begin
         err_fifo <= err_fifo | {fifo_overflow_error, fifo_underflow_error};
         if ((state != STREAM) || accept) begin
            stall_cnt <= '0;
         end else if (stall_cnt != STALL_W'(TIMEOUT)) begin
            stall_cnt <= stall_cnt + 1'b1;
            if (stall_cnt == STALL_W'(TIMEOUT - 1))
               err_timeout <= 1'b1;
         end
      end
   end
endmodule
